// File: rtl/mips_multi_core.sv
// Multicycle MIPS-subset core (FETCH/DECODE/EXEC/MEM/WB/HALT). Instruction and
// data memories are external and sit behind req/ready handshakes that may insert wait states.
module mips_multi_core #(
    parameter int DATA_W  = 32,
    parameter int IADDR_W = 10,
    parameter int DADDR_W = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [IADDR_W-1:0] imem_addr,
    input  logic               imem_ready,
    input  logic [31:0]        imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               dmem_ready,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic [4:0]         dbg_sel,
    output logic [DATA_W-1:0]  dbg_data,
    output logic               retire,
    output logic               illegal,
    output logic               halted
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;
    localparam logic [5:0] F_ADD    = 6'b100000;
    localparam logic [5:0] F_SUB    = 6'b100010;
    localparam logic [5:0] F_AND    = 6'b100100;
    localparam logic [5:0] F_OR     = 6'b100101;
    localparam logic [5:0] F_SLT    = 6'b101010;

    state_e             state_q;
    logic [IADDR_W-1:0] pc_q;
    logic [31:0]        ir_q;
    logic [DATA_W-1:0]  a_q, b_q, imm_q, alu_q, mdr_q;
    logic [DATA_W-1:0]  rf_q [32];
    logic               dmem_req_q, dmem_we_q, halted_q;

    logic [5:0]         opcode, funct;
    logic [4:0]         rs, rt, rd, wr_addr;
    logic               supported, is_branch, br_taken, is_mem;
    logic [DATA_W-1:0]  alu_res, wb_data;

    assign opcode    = ir_q[31:26];
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign funct     = ir_q[5:0];
    assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign is_mem    = (opcode == OP_LW) || (opcode == OP_SW);
    assign br_taken  = (opcode == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);
    assign wr_addr   = (opcode == OP_RTYPE) ? rd : rt;
    assign wb_data   = (opcode == OP_LW) ? mdr_q : alu_q;

    always_comb begin
        case (opcode)
            OP_RTYPE: supported = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW, OP_HALT: supported = 1'b1;
            default:  supported = 1'b0;
        endcase
    end

    always_comb begin
        alu_res = a_q + imm_q;
        if (opcode == OP_RTYPE) begin
            case (funct)
                F_SUB:   alu_res = a_q - b_q;
                F_AND:   alu_res = a_q & b_q;
                F_OR:    alu_res = a_q | b_q;
                F_SLT:   alu_res = {{(DATA_W-1){1'b0}}, $signed(a_q) < $signed(b_q)};
                default: alu_res = a_q + b_q;
            endcase
        end
    end

    always_comb begin
        case (state_q)
            S_DECODE: retire = !supported || (opcode == OP_J) || (opcode == OP_HALT);
            S_EXEC:   retire = is_branch;
            S_MEM:    retire = dmem_ready && (opcode == OP_SW);
            S_WB:     retire = 1'b1;
            default:  retire = 1'b0;
        endcase
    end

    // FETCH is the reset state, so the request is qualified by reset_n to stay low
    // while reset is held and to drop the moment reset is asserted.
    assign imem_req   = reset_n && (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign illegal    = (state_q == S_DECODE) && !supported;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = alu_q[DADDR_W-1:0];
    assign dmem_wdata = b_q;
    assign halted     = halted_q;
    assign dbg_data   = rf_q[dbg_sel];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_FETCH;
            pc_q       <= '0;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            imm_q      <= '0;
            alu_q      <= '0;
            mdr_q      <= '0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            halted_q   <= 1'b0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            case (state_q)
                S_FETCH: if (imem_ready) begin
                    ir_q    <= imem_rdata;
                    pc_q    <= pc_q + IADDR_W'(1);
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    a_q   <= rf_q[rs];
                    b_q   <= rf_q[rt];
                    imm_q <= DATA_W'($signed(ir_q[15:0]));
                    if (!supported) begin
                        state_q <= S_FETCH;
                    end else if (opcode == OP_J) begin
                        pc_q    <= ir_q[IADDR_W-1:0];
                        state_q <= S_FETCH;
                    end else if (opcode == OP_HALT) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_q <= alu_res;
                    if (is_branch) begin
                        if (br_taken) pc_q <= pc_q + imm_q[IADDR_W-1:0];
                        state_q <= S_FETCH;
                    end else if (is_mem) begin
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= (opcode == OP_SW);
                        state_q    <= S_MEM;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: if (dmem_ready) begin
                    dmem_req_q <= 1'b0;
                    dmem_we_q  <= 1'b0;
                    if (opcode == OP_LW) mdr_q <= dmem_rdata;
                    state_q <= (opcode == OP_SW) ? S_FETCH : S_WB;
                end
                S_WB: begin
                    if (wr_addr != 5'd0) rf_q[wr_addr] <= wb_data;
                    state_q <= S_FETCH;
                end
                default: state_q <= S_HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multi_core.sv
// Bench for mips_multi_core: an instruction-level model steps on every retire and is
// compared against the core each cycle; directed programs pin results with literal values.
module tb_mips_multi_core;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
    logic [9:0]  imem_addr, dmem_addr;
    logic [31:0] imem_rdata, dmem_wdata, dmem_rdata, dbg_data;
    logic [4:0]  dbg_sel = 5'd0;
    logic        retire, illegal, halted;

    always #5 clk = ~clk;

    mips_multi_core #(.DATA_W(32), .IADDR_W(10), .DADDR_W(10)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data),
        .retire(retire), .illegal(illegal), .halted(halted)
    );

    // memories with programmable wait states
    bit [31:0] imem [1024];
    bit [31:0] denv [1024];
    int iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
    assign imem_ready = imem_req && (icnt >= iwait);
    assign imem_rdata = imem[imem_addr];
    assign dmem_ready = dmem_req && (dcnt >= dwait);
    assign dmem_rdata = denv[dmem_addr];
    always @(posedge clk) begin
        icnt <= (imem_req && !imem_ready) ? icnt + 1 : 0;
        dcnt <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
        if (dmem_req && dmem_ready && dmem_we) denv[dmem_addr] <= dmem_wdata;
    end

    int total = 0, bad = 0;
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // architectural model
    bit [31:0] m_rf [32];
    bit [31:0] m_dmem [1024];
    int        m_pc = 0;
    bit        m_halted = 1'b0;
    int        cyc = 0, waits = 0, ill_seen = 0, n_illegal = 0, we_cycles = 0;
    int        ret_pc[$], ret_lat[$];

    function automatic bit is_ill(input bit [31:0] in);
        case (in[31:26])
            6'd0:    return !(in[5:0] inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd42});
            6'd2, 6'd4, 6'd5, 6'd8, 6'd35, 6'd43, 6'd63: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int base_lat(input bit [31:0] in);
        if (is_ill(in)) return 2;
        case (in[31:26])
            6'd2, 6'd63: return 2;
            6'd4, 6'd5:  return 3;
            6'd35:       return 5;
            default:     return 4;
        endcase
    endfunction

    task automatic step(input bit [31:0] in);
        bit [31:0] a, b, s, r;
        int np;
        a  = m_rf[in[25:21]];
        b  = m_rf[in[20:16]];
        s  = {{16{in[15]}}, in[15:0]};
        np = (m_pc + 1) % 1024;
        r  = 0;
        if (!is_ill(in)) begin
            case (in[31:26])
                6'd0: begin
                    case (in[5:0])
                        6'd32: r = a + b;
                        6'd34: r = a - b;
                        6'd36: r = a & b;
                        6'd37: r = a | b;
                        default: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    endcase
                    m_rf[in[15:11]] = r;
                end
                6'd8:  m_rf[in[20:16]] = a + s;
                6'd35: m_rf[in[20:16]] = m_dmem[(a + s) & 32'h3FF];
                6'd43: m_dmem[(a + s) & 32'h3FF] = b;
                6'd4:  if (a == b) np = (np + int'($signed(s))) & 1023;
                6'd5:  if (a != b) np = (np + int'($signed(s))) & 1023;
                6'd2:  np = int'(in[9:0]);
                default: m_halted = 1'b1;
            endcase
        end
        m_rf[0] = 0;
        m_pc    = np;
    endtask

    initial begin : cmp
        bit [31:0] instr, sx, ea;
        bit [5:0]  op;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk("rst_imem_req", imem_req, 0);
                chk("rst_dmem_req", dmem_req, 0);
                chk("rst_dmem_we", dmem_we, 0);
                chk("rst_retire", retire, 0);
                chk("rst_illegal", illegal, 0);
                chk("rst_halted", halted, 0);
                for (int i = 0; i < 32; i++) m_rf[i] = 0;
                m_pc = 0; m_halted = 0; cyc = 0; waits = 0; ill_seen = 0;
                chk("rst_dbg", dbg_data, 0);
            end else begin
                instr = imem[m_pc];
                op    = instr[31:26];
                sx    = {{16{instr[15]}}, instr[15:0]};
                chk("dbg", dbg_data, m_rf[dbg_sel]);
                if (m_halted) begin
                    chk("halt_hi", halted, 1);
                    chk("halt_imem_req", imem_req, 0);
                    chk("halt_dmem_req", dmem_req, 0);
                    chk("halt_retire", retire, 0);
                end else begin
                    cyc++;
                    if (imem_req && !imem_ready) waits++;
                    if (dmem_req && !dmem_ready) waits++;
                    chk("halt_lo", halted, 0);
                    if (imem_req) chk("fetch_addr", imem_addr, m_pc);
                    if (dmem_req) begin
                        ea = (m_rf[instr[25:21]] + sx) & 32'h3FF;
                        chk("dmem_op", (op == 6'd35) || (op == 6'd43), 1);
                        chk("dmem_addr", dmem_addr, ea);
                        chk("dmem_we", dmem_we, op == 6'd43);
                        if (op == 6'd43) chk("dmem_wdata", dmem_wdata, m_rf[instr[20:16]]);
                        if (dmem_we) we_cycles++;
                    end else begin
                        chk("we_idle", dmem_we, 0);
                    end
                    if (illegal) begin ill_seen++; n_illegal++; end
                    if (retire) begin
                        chk("latency", cyc, base_lat(instr) + waits);
                        chk("illegal_pulse", ill_seen, is_ill(instr));
                        ret_pc.push_back(m_pc);
                        ret_lat.push_back(cyc);
                        step(instr);
                        cyc = 0; waits = 0; ill_seen = 0;
                    end
                end
            end
        end
    end

    function automatic bit [31:0] enc_r(input int rs, input int rt, input int rd, input bit [5:0] f);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, f};
    endfunction
    function automatic bit [31:0] enc_i(input bit [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic bit [31:0] enc_j(input int a);
        return {6'b000010, 26'(a)};
    endfunction
    localparam bit [31:0] HALT = 32'hFC00_0000;

    task automatic begin_test();
        @(posedge clk); #1;
        reset_n = 1'b0;
        for (int i = 0; i < 1024; i++) imem[i] = 0;
        ret_pc.delete(); ret_lat.delete();
        n_illegal = 0; we_cycles = 0;
    endtask

    task automatic release_rst();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic run_to_halt(input int budget);
        for (int i = 0; i < budget && !halted; i++) begin
            @(posedge clk); #1;
            dbg_sel = 5'(i);
        end
        chk("halt_reached", halted, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic rd(input int r, input logic [31:0] e, input string nm);
        dbg_sel = 5'(r);
        #1 chk(nm, dbg_data, e);
    endtask

    task automatic chk_q(input string nm, input int got[$], input int exp[$]);
        chk({nm, "_n"}, got.size(), exp.size());
        foreach (exp[i]) if (i < got.size()) chk($sformatf("%s%0d", nm, i), got[i], exp[i]);
    endtask

    initial begin
        // add chain, zero wait states
        begin_test();
        #1;
        chk("reset_imem_req", imem_req, 0);
        chk("reset_halted", halted, 0);
        imem[0] = enc_i(6'd8, 0, 1, 5);
        imem[1] = enc_i(6'd8, 0, 2, -3);
        imem[2] = enc_r(1, 2, 3, 6'd32);
        imem[3] = HALT;
        release_rst();
        run_to_halt(100);
        rd(3, 32'd2, "add_r3");
        chk_q("t1_pc", ret_pc, '{0, 1, 2, 3});
        chk_q("t1_lat", ret_lat, '{4, 4, 4, 2});

        // ALU ops with one fetch wait state
        begin_test();
        iwait = 1;
        imem[0] = enc_i(6'd8, 0, 1, 5);
        imem[1] = enc_i(6'd8, 0, 2, -3);
        imem[2] = enc_r(1, 2, 4, 6'd34);
        imem[3] = enc_r(1, 2, 5, 6'd36);
        imem[4] = enc_r(1, 2, 6, 6'd37);
        imem[5] = enc_r(1, 2, 7, 6'd42);
        imem[6] = enc_r(2, 1, 8, 6'd42);
        imem[7] = HALT;
        release_rst();
        run_to_halt(200);
        rd(4, 32'd8, "sub");
        rd(5, 32'd5, "and");
        rd(6, 32'hFFFF_FFFD, "or");
        rd(7, 32'd0, "slt_12");
        rd(8, 32'd1, "slt_21");
        chk_q("t2_lat", ret_lat, '{5, 5, 5, 5, 5, 5, 5, 3});
        iwait = 0;

        // store then load with 3 data wait states
        begin_test();
        dwait = 3;
        imem[0] = enc_i(6'd8, 0, 1, 5);
        imem[1] = enc_i(6'd43, 0, 1, 4);
        imem[2] = enc_i(6'd35, 0, 4, 4);
        imem[3] = HALT;
        release_rst();
        run_to_halt(200);
        rd(4, 32'd5, "lw_r4");
        chk("dmem4", denv[4], 32'd5);
        chk("we_cycles", we_cycles, 4);
        chk_q("t3_lat", ret_lat, '{4, 7, 8, 2});
        dwait = 0;

        // branches, jumps and PC wrap
        begin_test();
        imem[0]    = enc_i(6'd5, 3, 0, 1);
        imem[1]    = enc_j(10);
        imem[2]    = HALT;
        imem[10]   = enc_i(6'd8, 0, 1, 1);
        imem[11]   = enc_j(6);
        imem[5]    = enc_i(6'd8, 2, 2, 1);
        imem[6]    = enc_i(6'd4, 2, 0, -2);
        imem[7]    = enc_i(6'd5, 2, 1, 4);
        imem[8]    = enc_j(1023);
        imem[1023] = enc_i(6'd8, 0, 3, 9);
        release_rst();
        run_to_halt(300);
        chk_q("t4_pc", ret_pc, '{0, 1, 10, 11, 6, 5, 6, 7, 8, 1023, 0, 2});
        chk_q("t4_lat", ret_lat, '{3, 2, 4, 2, 3, 4, 3, 3, 2, 4, 3, 2});

        // jump to self at the top of the address space
        begin_test();
        imem[0]    = enc_j(1023);
        imem[1023] = enc_j(1023);
        release_rst();
        repeat (20) @(posedge clk);
        #1;
        chk("selfloop_addr", imem_addr, 10'h3FF);
        chk("selfloop_pc0", ret_pc[0], 0);
        chk("selfloop_pc1", ret_pc[1], 1023);
        chk("selfloop_pc3", ret_pc[3], 1023);

        // write to $0, illegal opcode, halt
        begin_test();
        imem[0] = enc_i(6'd8, 0, 0, 7);
        imem[1] = {6'b010000, 26'd0};
        imem[2] = HALT;
        release_rst();
        run_to_halt(100);
        rd(0, 32'd0, "r0_zero");
        chk("n_illegal", n_illegal, 1);
        chk_q("t5_lat", ret_lat, '{4, 2, 2});
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("halted_hold", halted, 1);
            chk("halted_no_fetch", imem_req, 0);
        end

        // reset asserted during a data wait
        begin_test();
        dwait = 20;
        imem[0] = enc_i(6'd8, 0, 1, 5);
        imem[1] = enc_i(6'd43, 0, 1, 8);
        imem[2] = HALT;
        release_rst();
        for (int i = 0; i < 50 && !dmem_req; i++) begin
            @(posedge clk); #1;
        end
        chk("mem_reached", dmem_req, 1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_dmem_req", dmem_req, 0);
        chk("abort_imem_req", imem_req, 0);
        for (int r = 0; r < 32; r++) rd(r, 32'd0, $sformatf("abort_r%0d", r));
        chk("abort_nowrite", denv[8], 0);
        @(posedge clk); #1;
        dwait = 0;
        reset_n = 1'b1;
        #1;
        chk("resume_req", imem_req, 1);
        chk("resume_addr", imem_addr, 0);
        run_to_halt(100);
        chk("resume_dmem8", denv[8], 32'd5);
        rd(1, 32'd5, "resume_r1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
